button_conditioner: RTL and testbench

Multi-channel successor to the single-input debouncer for board push-buttons and switches. Each channel synchronises its raw input and debounces it with a per-channel stability counter. It then emits a debounced level, one-cycle press/release pulses, and long-press and auto-repeat events. It sits between the FPGA pins and the UI/control FSMs, so downstream logic consumes clean single-cycle events instead of polling levels.

---
 rtl/button_pkg.sv | 17 +
 rtl/button_conditioner_if.sv | 24 ++
 rtl/button_channel.sv | 108 ++++++++++
 rtl/button_conditioner.sv | 49 ++++
 tb/tb_button_conditioner.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/button_pkg.sv
// Shared types and sizing helper for the multi-channel button conditioner.
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    LONG     = 2'd2
  } btn_state_e;

  // Bits needed to hold values up to max(a, b).
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Pin-side inputs and conditioned event outputs of the button conditioner.
interface button_conditioner_if #(
  parameter int CHANNELS = 4
);

  logic [CHANNELS-1:0] noisy_in;
  logic [CHANNELS-1:0] clean_out;
  logic [CHANNELS-1:0] rise_pulse;
  logic [CHANNELS-1:0] fall_pulse;
  logic [CHANNELS-1:0] long_press;
  logic [CHANNELS-1:0] long_pulse;
  logic [CHANNELS-1:0] repeat_pulse;

  modport master (
    output noisy_in,
    input  clean_out, rise_pulse, fall_pulse, long_press, long_pulse, repeat_pulse
  );

  modport slave (
    input  noisy_in,
    output clean_out, rise_pulse, fall_pulse, long_press, long_pulse, repeat_pulse
  );

endinterface

// File: rtl/button_channel.sv
// One input: 2-FF synchroniser, debounce counter, press FSM and hold counter.
//   state    | meaning
//   RELEASED | debounced level is 0
//   PRESSED  | debounced level is 1, hold counter running toward long press
//   LONG     | long press reached, hold counter paces auto-repeat
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 27000,
  parameter int LONG_CYCLES     = 13500000,
  parameter int REPEAT_CYCLES   = 2700000,
  parameter bit INVERT          = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic noisy,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic long_press,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES, 0);
  localparam int HW = cnt_width(LONG_CYCLES, REPEAT_CYCLES);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam bit REP_EN = (REPEAT_CYCLES > 0);

  btn_state_e      state;
  logic [1:0]      sync;
  logic [DW-1:0]   deb_cnt;
  logic [HW-1:0]   hold_cnt;
  logic            s;
  logic            differs;
  logic            accept;

  assign s       = sync[1] ^ INVERT;
  assign differs = (s != clean);
  assign accept  = differs && (deb_cnt == DEB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RELEASED;
      sync         <= '0;
      deb_cnt      <= '0;
      hold_cnt     <= '0;
      clean        <= 1'b0;
      rise         <= 1'b0;
      fall         <= 1'b0;
      long_press   <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      sync         <= {sync[0], noisy};
      rise         <= 1'b0;
      fall         <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;

      if (!differs || accept) deb_cnt <= '0;
      else                    deb_cnt <= deb_cnt + 1'b1;
      if (accept) clean <= s;

      // An accepted release outranks long-press entry and repeat in the same cycle.
      case (state)
        RELEASED: begin
          if (accept) begin
            state    <= PRESSED;
            rise     <= 1'b1;
            hold_cnt <= '0;
          end
        end
        PRESSED: begin
          if (accept) begin
            state <= RELEASED;
            fall  <= 1'b1;
          end else if (hold_cnt == LONG_LAST) begin
            state      <= LONG;
            long_press <= 1'b1;
            long_pulse <= 1'b1;
            hold_cnt   <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        LONG: begin
          if (accept) begin
            state      <= RELEASED;
            fall       <= 1'b1;
            long_press <= 1'b0;
          end else if (REP_EN) begin
            if (hold_cnt == REP_LAST) begin
              repeat_pulse <= 1'b1;
              hold_cnt     <= '0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        default: state <= RELEASED;
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: one independent button_channel per input.
module button_conditioner
  import button_pkg::*;
#(
  parameter int                  CHANNELS        = 4,
  parameter int                  DEBOUNCE_CYCLES = 27000,
  parameter int                  LONG_CYCLES     = 13500000,
  parameter int                  REPEAT_CYCLES   = 2700000,
  parameter logic [CHANNELS-1:0] INVERT_MASK     = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  button_conditioner_if.slave  bus
);

  logic [CHANNELS-1:0] clean;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic [CHANNELS-1:0] lpress;
  logic [CHANNELS-1:0] lpulse;
  logic [CHANNELS-1:0] rpulse;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .INVERT          (INVERT_MASK[i])
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .noisy        (bus.noisy_in[i]),
      .clean        (clean[i]),
      .rise         (rise[i]),
      .fall         (fall[i]),
      .long_press   (lpress[i]),
      .long_pulse   (lpulse[i]),
      .repeat_pulse (rpulse[i])
    );
  end

  assign bus.clean_out    = clean;
  assign bus.rise_pulse   = rise;
  assign bus.fall_pulse   = fall;
  assign bus.long_press   = lpress;
  assign bus.long_pulse   = lpulse;
  assign bus.repeat_pulse = rpulse;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench: segment table with event counts, reset corner cases, random stimulus vs model.
module tb_button_conditioner;

  localparam int         CH  = 2;
  localparam int         DEB = 4;
  localparam int         LNG = 10;
  localparam int         REP = 3;
  localparam logic [1:0] INV = 2'b10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  button_conditioner_if #(.CHANNELS(CH)) bus ();

  button_conditioner #(
    .CHANNELS        (CH),
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LNG),
    .REPEAT_CYCLES   (REP),
    .INVERT_MASK     (INV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: pin delay line, sliding window of synced samples, time since press.
  bit         dly [CH][$];
  bit         win [CH][$];
  bit         m_clean [CH];
  int         age [CH];
  logic [1:0] e_clean, e_rise, e_fall, e_lp, e_lpul, e_rep;

  int cnt_rise [CH];
  int cnt_fall [CH];
  int cnt_long [CH];
  int cnt_rep  [CH];

  typedef struct {
    logic [1:0] pin;
    int         cycles;
    int         rise0, fall0, long0, rep0, rise1, fall1;
    logic [1:0] clean_end;
  } seg_t;
  seg_t tbl[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      dly[c].delete();
      dly[c].push_back(1'b0);
      dly[c].push_back(1'b0);
      win[c].delete();
      m_clean[c] = 1'b0;
      age[c] = 0;
    end
    e_clean = '0; e_rise = '0; e_fall = '0; e_lp = '0; e_lpul = '0; e_rep = '0;
  endtask

  task automatic model_step(input logic [1:0] pin);
    for (int c = 0; c < CH; c++) begin
      bit s, prev, all_diff;
      s = dly[c].pop_front() ^ INV[c];
      dly[c].push_back(pin[c]);
      win[c].push_back(s);
      if (win[c].size() > DEB) void'(win[c].pop_front());
      all_diff = (win[c].size() == DEB);
      for (int k = 0; k < win[c].size(); k++)
        if (win[c][k] == m_clean[c]) all_diff = 1'b0;
      prev = m_clean[c];
      if (all_diff) m_clean[c] = ~m_clean[c];
      e_rise[c]  = m_clean[c] & ~prev;
      e_fall[c]  = ~m_clean[c] & prev;
      if (e_rise[c]) age[c] = 0;
      else if (m_clean[c]) age[c]++;
      e_clean[c] = m_clean[c];
      e_lp[c]    = m_clean[c] && (age[c] >= LNG);
      e_lpul[c]  = m_clean[c] && (age[c] == LNG);
      e_rep[c]   = m_clean[c] && (REP > 0) && (age[c] > LNG) && (((age[c] - LNG) % REP) == 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step(bus.noisy_in);
    #1;
    cyc++;
    if (rst_n) begin
      check($sformatf("cycle %0d outputs", cyc),
            {20'd0, bus.clean_out, bus.rise_pulse, bus.fall_pulse,
             bus.long_press, bus.long_pulse, bus.repeat_pulse},
            {20'd0, e_clean, e_rise, e_fall, e_lp, e_lpul, e_rep});
      for (int c = 0; c < CH; c++) begin
        cnt_rise[c] += int'(bus.rise_pulse[c]);
        cnt_fall[c] += int'(bus.fall_pulse[c]);
        cnt_long[c] += int'(bus.long_pulse[c]);
        cnt_rep[c]  += int'(bus.repeat_pulse[c]);
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic add_seg(input logic [1:0] pin, input int cycles, input int r0, input int f0,
                         input int l0, input int p0, input int r1, input int f1,
                         input logic [1:0] ce);
    seg_t t;
    t.pin = pin; t.cycles = cycles; t.rise0 = r0; t.fall0 = f0; t.long0 = l0; t.rep0 = p0;
    t.rise1 = r1; t.fall1 = f1; t.clean_end = ce;
    tbl.push_back(t);
  endtask

  task automatic edges_to_rise(input string name);
    int n;
    bit found;
    n = 0;
    found = 1'b0;
    while (n < 20 && !found) begin
      tick();
      n++;
      if (bus.rise_pulse[0]) found = 1'b1;
    end
    check(name, n, 6);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ch1 is active-low: pin 1 is idle, pin 0 is pressed
    bus.noisy_in = 2'b10;
    model_reset();
    do_reset();
    check("reset clean_out", {30'd0, bus.clean_out}, 32'd0);

    //        pin    cyc  r0 f0 l0 p0 r1 f1 clean
    add_seg(2'b10, 10, 0, 0, 0, 0, 0, 0, 2'b00);  // inverted ch1 held idle from reset
    add_seg(2'b11,  3, 0, 0, 0, 0, 0, 0, 2'b00);  // 3-cycle glitch
    add_seg(2'b10, 10, 0, 0, 0, 0, 0, 0, 2'b00);
    add_seg(2'b11,  4, 0, 0, 0, 0, 0, 0, 2'b00);  // 4-cycle glitch accepted
    add_seg(2'b10, 10, 1, 1, 0, 0, 0, 0, 2'b00);
    add_seg(2'b11, 40, 1, 0, 1, 8, 0, 0, 2'b01);  // long press + repeats
    add_seg(2'b10, 10, 0, 1, 0, 1, 0, 0, 2'b00);  // repeat at fall edge suppressed
    add_seg(2'b11,  8, 1, 0, 0, 0, 0, 0, 2'b01);  // release accepted at r+8
    add_seg(2'b10, 10, 0, 1, 0, 0, 0, 0, 2'b00);
    add_seg(2'b11, 10, 1, 0, 0, 0, 0, 0, 2'b01);  // release accepted at r+10
    add_seg(2'b10, 10, 0, 1, 0, 0, 0, 0, 2'b00);
    add_seg(2'b11, 11, 1, 0, 0, 0, 0, 0, 2'b01);  // release accepted at r+11
    add_seg(2'b10, 10, 0, 1, 1, 0, 0, 0, 2'b00);
    add_seg(2'b01, 10, 1, 0, 0, 0, 1, 0, 2'b11);  // simultaneous press both channels
    add_seg(2'b10, 10, 0, 1, 0, 0, 0, 1, 2'b00);

    for (int i = 0; i < tbl.size(); i++) begin
      for (int c = 0; c < CH; c++) begin
        cnt_rise[c] = 0; cnt_fall[c] = 0; cnt_long[c] = 0; cnt_rep[c] = 0;
      end
      bus.noisy_in = tbl[i].pin;
      repeat (tbl[i].cycles) tick();
      check($sformatf("seg%0d rise0", i), cnt_rise[0], tbl[i].rise0);
      check($sformatf("seg%0d fall0", i), cnt_fall[0], tbl[i].fall0);
      check($sformatf("seg%0d long0", i), cnt_long[0], tbl[i].long0);
      check($sformatf("seg%0d rep0", i),  cnt_rep[0],  tbl[i].rep0);
      check($sformatf("seg%0d rise1", i), cnt_rise[1], tbl[i].rise1);
      check($sformatf("seg%0d fall1", i), cnt_fall[1], tbl[i].fall1);
      check($sformatf("seg%0d clean", i), {30'd0, bus.clean_out}, {30'd0, tbl[i].clean_end});
    end

    // Reset while in LONG: outputs drop at once; held input re-reported 6 edges after release
    bus.noisy_in = 2'b11;
    repeat (20) tick();
    check("long_press before reset", {31'd0, bus.long_press[0]}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("outputs at reset in LONG",
          {20'd0, bus.clean_out, bus.rise_pulse, bus.fall_pulse,
           bus.long_press, bus.long_pulse, bus.repeat_pulse}, 32'd0);
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    edges_to_rise("edges to rise after LONG reset");

    // Reset with the debounce counter at 2
    bus.noisy_in = 2'b10;
    repeat (15) tick();
    bus.noisy_in = 2'b11;
    repeat (4) tick();
    check("clean before mid-count reset", {31'd0, bus.clean_out[0]}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("outputs at mid-count reset",
          {20'd0, bus.clean_out, bus.rise_pulse, bus.fall_pulse,
           bus.long_press, bus.long_pulse, bus.repeat_pulse}, 32'd0);
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    edges_to_rise("edges to rise after mid-count reset");

    // Random stimulus against the model
    bus.noisy_in = 2'b10;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      int hold;
      bus.noisy_in = 2'($urandom_range(0, 3));
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 40))
                                         : int'($urandom_range(1, 7));
      repeat (hold) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
